// File: rtl/kmap_pkg.sv
// Shared constants and FSM state encoding for the Karnaugh-map sweep controller.
package kmap_pkg;

  localparam int KMAP_INPUTS  = 4;
  localparam int KMAP_ENTRIES = 16;
  // Holds 0..16, so one bit wider than the index.
  localparam int FAIL_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/kmap_sweep_ctrl.sv
// Walks kmap_x through all 16 input codes, waits SETTLE_CYCLES per code, samples
// kmap_f into truth_table and compares it against a golden table latched at start.
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KMAP_ENTRIES-1:0] expected,
  output logic [KMAP_INPUTS-1:0]  kmap_x,
  input  logic                    kmap_f,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [KMAP_ENTRIES-1:0] truth_table,
  output logic [FAIL_W-1:0]       fail_count,
  output logic [KMAP_INPUTS-1:0]  first_fail_idx
);

  localparam logic [3:0]             SETTLE_LOAD = SETTLE_CYCLES[3:0];
  localparam logic [3:0]             SETTLE_LAST = 4'd1;
  localparam logic [KMAP_INPUTS-1:0] X_ONE       = 1;
  localparam logic [KMAP_INPUTS-1:0] X_LAST      = '1;
  localparam logic [FAIL_W-1:0]      FAIL_ONE    = 1;

  state_t                    state;
  logic [KMAP_ENTRIES-1:0]   exp_lat;
  logic [3:0]                settle_cnt;

  // Handshake: start is a request sampled only in IDLE while done is low;
  // done is a one-cycle completion pulse, and busy covers SETTLE..DONE.
  // kmap_x doubles as the sweep index, so the two can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      exp_lat        <= '0;
      settle_cnt     <= '0;
      kmap_x         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      truth_table    <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            state          <= ST_SETTLE;
            exp_lat        <= expected;
            settle_cnt     <= SETTLE_LOAD;
            kmap_x         <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            truth_table    <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_LAST;
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_SAMPLE;
            end
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            truth_table[kmap_x] <= kmap_f;
            if (kmap_f != exp_lat[kmap_x]) begin
              fail_count <= fail_count + FAIL_ONE;
              if (fail_count == '0) begin
                first_fail_idx <= kmap_x;
              end
            end
            if (kmap_x == X_LAST) begin
              state <= ST_DONE;
            end else begin
              kmap_x     <= kmap_x + X_ONE;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          // fail_count already includes the index-15 sample written on entry.
          done  <= 1'b1;
          pass  <= (fail_count == '0);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: table-driven sweeps plus hand-written
// sequences for start-while-busy, abort and reset mid-sweep.
module tb_kmap_sweep_ctrl;
  import kmap_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, abort1, start3, abort3;
  logic [15:0] expected;
  logic [15:0] func;

  logic [3:0]  x1, x3;
  logic        f1, f3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [15:0] tt1, tt3;
  logic [4:0]  fc1, fc3;
  logic [3:0]  ffi1, ffi3;

  // Function-under-test stub: a programmable truth table.
  assign f1 = func[x1];
  assign f3 = func[x3];

  kmap_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(expected), .kmap_x(x1), .kmap_f(f1), .busy(busy1),
    .done(done1), .pass(pass1), .truth_table(tt1), .fail_count(fc1),
    .first_fail_idx(ffi1)
  );

  kmap_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .expected(expected), .kmap_x(x3), .kmap_f(f3), .busy(busy3),
    .done(done3), .pass(pass3), .truth_table(tt3), .fail_count(fc3),
    .first_fail_idx(ffi3)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, need %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the chosen DUT; lat = edges from the start-sampling edge to
  // the cycle in which done is seen high, or -1 on timeout.
  task automatic sweep(input bit use3, output int lat);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if ((use3 ? done3 : done1) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] func;
    logic [15:0] exp_in;
    logic [15:0] tt;
    logic [4:0]  fc;
    logic [3:0]  ffi;
    logic        pass;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int first;
    int dones;
    int found;

    vecs[0] = '{func: 16'h6996, exp_in: 16'h6996, tt: 16'h6996, fc: 5'd0,  ffi: 4'd0,  pass: 1'b1};
    vecs[1] = '{func: 16'h6996, exp_in: 16'h6997, tt: 16'h6996, fc: 5'd1,  ffi: 4'd0,  pass: 1'b0};
    vecs[2] = '{func: 16'h6996, exp_in: 16'h9669, tt: 16'h6996, fc: 5'd16, ffi: 4'd0,  pass: 1'b0};
    vecs[3] = '{func: 16'h0000, exp_in: 16'h8000, tt: 16'h0000, fc: 5'd1,  ffi: 4'd15, pass: 1'b0};
    vecs[4] = '{func: 16'hFFFF, exp_in: 16'h00FF, tt: 16'hFFFF, fc: 5'd8,  ffi: 4'd8,  pass: 1'b0};
    vecs[5] = '{func: 16'hA5A5, exp_in: 16'hA5A5, tt: 16'hA5A5, fc: 5'd0,  ffi: 4'd0,  pass: 1'b1};
    vecs[6] = '{func: 16'h1234, exp_in: 16'h1204, tt: 16'h1234, fc: 5'd2,  ffi: 4'd4,  pass: 1'b0};

    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    expected = 16'h0; func = 16'h6996;
    #1;
    check("reset_busy", {15'd0, busy1}, 16'd0);
    check("reset_done", {15'd0, done1}, 16'd0);
    check("reset_pass", {15'd0, pass1}, 16'd0);
    check("reset_x",    {12'd0, x1},    16'd0);
    check("reset_tt",   tt1,            16'd0);
    check("reset_fc",   {11'd0, fc1},   16'd0);
    check("reset_ffi",  {12'd0, ffi1},  16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven sweeps ----------------
    for (int v = 0; v < 7; v++) begin
      func     = vecs[v].func;
      expected = vecs[v].exp_in;
      sweep(1'b0, lat);
      check($sformatf("v%0d_latency", v), 16'(lat), 16'd33);
      check($sformatf("v%0d_tt", v),   tt1,            vecs[v].tt);
      check($sformatf("v%0d_fc", v),   {11'd0, fc1},   {11'd0, vecs[v].fc});
      check($sformatf("v%0d_ffi", v),  {12'd0, ffi1},  {12'd0, vecs[v].ffi});
      check($sformatf("v%0d_pass", v), {15'd0, pass1}, {15'd0, vecs[v].pass});
      check($sformatf("v%0d_x_nowrap", v), {12'd0, x1}, 16'd15);
      tick();
      check($sformatf("v%0d_done_once", v), {15'd0, done1}, 16'd0);
      check($sformatf("v%0d_hold_tt", v), tt1, vecs[v].tt);
    end

    // ---------------- start while busy, start during done, expected changed ----------------
    func = 16'h6996; expected = 16'h6996;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    expected = 16'h0000;
    first = -1; dones = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10 || k == 34) start1 = 1'b1;
      if (k == 11 || k == 35) start1 = 1'b0;
      tick();
      if (done1 === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    check("busy_start_latency", 16'(first), 16'd33);
    check("busy_start_dones",   16'(dones), 16'd1);
    check("start_on_done_ignored", {15'd0, busy1}, 16'd0);
    check("expected_latched_pass", {15'd0, pass1}, 16'd1);

    // ---------------- abort at kmap_x == 7 ----------------
    func = 16'h6996; expected = 16'h6997;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (x1 == 4'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    check("abort_reach_x7", 16'(found), 16'd1);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_busy", {15'd0, busy1}, 16'd0);
    check("abort_x",    {12'd0, x1},    16'd7);
    check("abort_pass", {15'd0, pass1}, 16'd0);
    check("abort_fc",   {11'd0, fc1},   16'd1);
    check("abort_tt",   tt1,            16'h0016);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done1 === 1'b1) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);
    check("abort_x_held",  {12'd0, x1}, 16'd7);

    // ---------------- start and abort together in IDLE: start wins ----------------
    expected = 16'h6996;
    start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    check("start_beats_abort", {15'd0, busy1}, 16'd1);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done1 === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("start_abort_latency", 16'(lat), 16'd33);
    check("start_abort_pass", {15'd0, pass1}, 16'd1);

    // ---------------- reset mid-sweep, SETTLE_CYCLES=3 ----------------
    func = 16'h6996; expected = 16'h6996;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    repeat (20) tick();
    check("pre_reset_busy3", {15'd0, busy3}, 16'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy3", {15'd0, busy3}, 16'd0);
    check("rst_x3",    {12'd0, x3},    16'd0);
    check("rst_tt3",   tt3,            16'd0);
    check("rst_fc3",   {11'd0, fc3},   16'd0);
    check("rst_pass3", {15'd0, pass3}, 16'd0);
    check("rst_done3", {15'd0, done3}, 16'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_needs_start", {15'd0, busy3}, 16'd0);
    sweep(1'b1, lat);
    check("s3_latency", 16'(lat), 16'd65);
    check("s3_tt",   tt3,            16'h6996);
    check("s3_fc",   {11'd0, fc3},   16'd0);
    check("s3_pass", {15'd0, pass3}, 16'd1);
    check("s3_x",    {12'd0, x3},    16'd15);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kmap_sweep_ctrl.md
KMAP_SWEEP_CTRL -- requirements
Module: kmap_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving clock cycles between driving kmap_x and sampling kmap_f (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: cancels a sweep in progress.
REQ-006 SHALL have port expected, input, 16 bits: golden truth table; bit i is the expected f for x=i.
REQ-007 SHALL have port kmap_x, output, 4 bits: registered drive to the 4-input combinational function under test.
REQ-008 SHALL have port kmap_f, input, 1 bit: output of the function under test.
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port truth_table, output, 16 bits: captured kmap_f per index.
REQ-013 SHALL have port fail_count, output, 5 bits: mismatch count, range 0..16.
REQ-014 SHALL have port first_fail_idx, output, 4 bits: lowest mismatching index; 0 when there is no mismatch.

Function
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE with start=1 SHALL go to SETTLE and, on the same edge, latch expected, clear truth_table, fail_count, first_fail_idx and pass, set idx=0 and kmap_x=0, and load the settle counter with SETTLE_CYCLES.
REQ-017 SETTLE SHALL decrement the settle counter each cycle and go to SAMPLE on the cycle the counter equals 1.
REQ-018 SAMPLE SHALL write kmap_f into truth_table[idx] and compare it with the latched expected[idx].
REQ-019 On a mismatch in SAMPLE, the block SHALL increment fail_count and set first_fail_idx=idx if this is the first mismatch of the sweep.
REQ-020 SAMPLE with idx<15 SHALL increment idx and kmap_x, reload the settle counter and return to SETTLE.
REQ-021 SAMPLE with idx=15 SHALL go to DONE; kmap_x SHALL NOT wrap.
REQ-022 DONE SHALL assert done for exactly one cycle, set pass to (final fail_count==0), including the idx-15 sample, and return to IDLE.
REQ-023 busy SHALL be high in SETTLE, SAMPLE and DONE, and low in IDLE.
REQ-024 Latency: done SHALL be high in the cycle that begins 16*(SETTLE_CYCLES+1)+1 rising edges after the edge that samples start (33 when SETTLE_CYCLES=1).
REQ-025 start SHALL be ignored while busy=1; start and done in the same cycle SHALL NOT start a new sweep.
REQ-026 abort=1 in SETTLE or SAMPLE SHALL go to IDLE on the next edge, with done not pulsed, pass=0, partial truth_table and fail_count held, and kmap_x held.
REQ-027 abort in DONE or IDLE SHALL be ignored; if abort and start are both high in IDLE, start SHALL win.
REQ-028 Results SHALL hold stable from DONE until the next accepted start.
REQ-029 expected SHALL only be read through the copy latched at start; later changes SHALL NOT affect the sweep.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, with kmap_x=0, busy=0, done=0, pass=0, truth_table=0, fail_count=0 and first_fail_idx=0.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep; after release, the block SHALL require a new start.
REQ-032 Reset release SHALL be treated as synchronous to clk by the integrator; the block SHALL NOT synchronise it internally.

Structure
REQ-033 Package kmap_pkg SHALL hold the state enum, KMAP_INPUTS=4, KMAP_ENTRIES=16 and the fail_count width.
REQ-034 The block SHALL contain no sub-module; the existing karnaugh_map SHALL be wired at the level above (kmap_x to x, f to kmap_f).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Scenario, clean pass: stub f=^x, expected=16'h6996, SETTLE_CYCLES=1 -> truth_table=16'h6996, fail_count=0, pass=1, done 33 cycles after start.
REQ-037 Scenario, single mismatch: same stub, expected=16'h6997 -> fail_count=1, first_fail_idx=0, pass=0.
REQ-038 Scenario, all mismatch: expected=16'h9669 -> fail_count=16, first_fail_idx=0, truth_table=16'h6996.
REQ-039 Scenario, start while busy: pulse start again at cycle 10 -> no restart, done still at cycle 33, a single done pulse.
REQ-040 Scenario, abort: assert abort while kmap_x=7 -> busy=0 on the next cycle, no done pulse, pass=0, kmap_x stays 7.
REQ-041 Scenario, reset mid-sweep: assert rst_n=0 mid-sweep between edges -> outputs clear immediately; a new start after release sweeps 0..15 normally, checked with SETTLE_CYCLES=3 giving done at cycle 65.
